// File: rtl/bit_reverse_unit.sv
// bit_reverse_unit: group-serial bit permutation engine.
// A word is accepted in IDLE. One GROUP_W-bit group of the result is built per
// RUN cycle. The finished word is presented in DONE until the consumer takes it.
module bit_reverse_unit #(
   parameter int N_BITS  = 8,
   parameter int GROUP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_BITS-1:0] in_data,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_BITS-1:0] out_data,
   output logic              busy
);

   localparam int NG  = N_BITS / GROUP_W;
   localparam int G_W = (NG > 1) ? $clog2(NG) : 1;
   localparam logic [G_W-1:0] G_LAST = G_W'(NG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state_reg;
   logic [G_W-1:0]      g_reg;
   logic [N_BITS-1:0]   data_reg;
   logic [1:0]          mode_reg;
   logic [N_BITS-1:0]   work_reg;
   logic [N_BITS-1:0]   out_data_reg;
   logic                in_ready_reg;
   logic                out_valid_reg;
   logic                busy_reg;

   logic [GROUP_W-1:0]  src_grp;
   logic [GROUP_W-1:0]  rev_grp;
   logic [GROUP_W-1:0]  new_grp;
   logic [N_BITS-1:0]   work_next;
   int                  g_int;
   int                  src_int;

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign busy      = busy_reg;

   // Pick the source group: modes 01 and 10 read groups in mirrored order.
   always_comb begin
      g_int   = int'(g_reg);
      src_int = (mode_reg[0] ^ mode_reg[1]) ? (NG - 1 - g_int) : g_int;
      src_grp = '0;
      for (int k = 0; k < NG; k++) begin
         if (k == src_int) begin
            src_grp = data_reg[k*GROUP_W +: GROUP_W];
         end
      end
   end

   // Bit-reversed copy of the selected source group.
   for (genvar gi = 0; gi < GROUP_W; gi++) begin : g_rev
      assign rev_grp[gi] = src_grp[GROUP_W-1-gi];
   end

   // Modes 01 and 11 reverse the bits. Insert the result at output group g.
   always_comb begin
      new_grp   = mode_reg[0] ? rev_grp : src_grp;
      work_next = work_reg;
      for (int k = 0; k < NG; k++) begin
         if (k == g_int) begin
            work_next[k*GROUP_W +: GROUP_W] = new_grp;
         end
      end
   end

   // Control FSM with registered handshake and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         g_reg         <= '0;
         data_reg      <= '0;
         mode_reg      <= '0;
         work_reg      <= '0;
         out_data_reg  <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  data_reg     <= in_data;
                  mode_reg     <= in_mode;
                  g_reg        <= '0;
                  work_reg     <= '0;
                  state_reg    <= RUN;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end
            RUN: begin
               work_reg <= work_next;
               if (g_reg == G_LAST) begin
                  g_reg         <= '0;
                  out_data_reg  <= work_next;
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end else begin
                  g_reg <= g_reg + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               g_reg         <= '0;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_reverse_unit.sv
// Scoreboard bench for bit_reverse_unit (8/4 main instance plus 16/4 and 16/16).
// The stimulus pushes the expected word and its expected first-valid cycle.
// The monitors pop these entries and compare them to what the DUT presents.
module tb_bit_reverse_unit;

   localparam int NG8 = 2;
   localparam int NGA = 4;
   localparam int NGB = 1;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_mode;
   logic        in_ready, out_valid, busy;
   logic [7:0]  out_data;

   logic        in_valid16;
   logic [15:0] in_data16;
   logic [1:0]  in_mode16;
   logic        in_ready_a, out_valid_a, busy_a;
   logic [15:0] out_data_a;
   logic        in_ready_b, out_valid_b, busy_b;
   logic [15:0] out_data_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   exp_t q8[$];
   exp_t qa[$];
   exp_t qb[$];

   bit_reverse_unit #(.N_BITS(8), .GROUP_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   bit_reverse_unit #(.N_BITS(16), .GROUP_W(4)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready_a),
      .in_data(in_data16), .in_mode(in_mode16), .out_valid(out_valid_a),
      .out_ready(1'b1), .out_data(out_data_a), .busy(busy_a)
   );

   bit_reverse_unit #(.N_BITS(16), .GROUP_W(16)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready_b),
      .in_data(in_data16), .in_mode(in_mode16), .out_valid(out_valid_b),
      .out_ready(1'b1), .out_data(out_data_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s", nm);
   endtask

   // Monitor for the 8-bit instance: first valid cycle pops, later cycles check hold.
   logic       prev8 = 1'b0;
   logic [7:0] cur8  = '0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) prev8 = 1'b0;
      else if (out_valid) begin
         if (!prev8) begin
            if (q8.size() == 0) fail_now("spurious_out8");
            else begin
               e    = q8.pop_front();
               cur8 = e.data[7:0];
               check("data8", {24'h0, out_data}, {24'h0, cur8});
               check("latency8", cyc, e.cyc);
               $display("txn8 out_data=%h expected=%h cycle=%0d", out_data, cur8, cyc);
            end
         end else check("hold8", {24'h0, out_data}, {24'h0, cur8});
         prev8 = 1'b1;
      end else prev8 = 1'b0;
   end

   logic prev_a = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (out_valid_a && !prev_a) begin
         if (qa.size() == 0) fail_now("spurious_out16a");
         else begin
            e = qa.pop_front();
            check("data16a", {16'h0, out_data_a}, {16'h0, e.data});
            check("latency16a", cyc, e.cyc);
            $display("txn16a out_data=%h expected=%h cycle=%0d", out_data_a, e.data, cyc);
         end
      end
      prev_a = out_valid_a;
   end

   logic prev_b = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (out_valid_b && !prev_b) begin
         if (qb.size() == 0) fail_now("spurious_out16b");
         else begin
            e = qb.pop_front();
            check("data16b", {16'h0, out_data_b}, {16'h0, e.data});
            check("latency16b", cyc, e.cyc);
            $display("txn16b out_data=%h expected=%h cycle=%0d", out_data_b, e.data, cyc);
         end
      end
      prev_b = out_valid_b;
   end

   // Offer a word and leave in_valid high. Return 1 ns after the accepting edge.
   task automatic send8(input logic [7:0] d, input logic [1:0] m, input logic [7:0] e, output int acc);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_mode = m;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      if (!in_ready) fail_now("accept_timeout8");
      acc = cyc + 1;
      q8.push_back('{data: {8'h00, e}, cyc: acc + NG8});
      @(posedge clk); #1;
   endtask

   task automatic drain8();
      int t = 0;
      while ((q8.size() != 0 || out_valid) && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail_now("drain_timeout8");
   endtask

   task automatic send16(input logic [15:0] d, input logic [1:0] m, input logic [15:0] ea, input logic [15:0] eb);
      int t = 0;
      int acc;
      @(negedge clk);
      in_valid16 = 1'b1; in_data16 = d; in_mode16 = m;
      while (!(in_ready_a && in_ready_b) && t < 100) begin @(negedge clk); t++; end
      if (!(in_ready_a && in_ready_b)) fail_now("accept_timeout16");
      acc = cyc + 1;
      qa.push_back('{data: ea, cyc: acc + NGA});
      qb.push_back('{data: eb, cyc: acc + NGB});
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      t = 0;
      while ((qa.size() != 0 || qb.size() != 0 || out_valid_a || out_valid_b) && t < 100) begin
         @(negedge clk); t++;
      end
      if (t >= 100) fail_now("drain_timeout16");
   endtask

   initial begin
      logic [7:0] vd [4] = '{8'hC5, 8'hC5, 8'hC5, 8'hC5};
      logic [1:0] vm [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [7:0] ve [4] = '{8'hC5, 8'hA3, 8'h5C, 8'h3A};
      logic [7:0] bd [4] = '{8'h3C, 8'h01, 8'h12, 8'hF0};
      logic [1:0] bm [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      logic [7:0] be [4] = '{8'h3C, 8'h10, 8'h84, 8'hF0};
      int acc, prev_acc, t;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
      in_valid16 = 1'b0; in_data16 = '0; in_mode16 = '0;
      #1;
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_out_data", {24'h0, out_data}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Each mode on 0xC5 with the consumer always ready.
      for (int i = 0; i < 4; i++) begin
         send8(vd[i], vm[i], ve[i], acc);
         in_valid = 1'b0;
         drain8();
      end

      // Input changes during RUN must not disturb the latched word.
      send8(8'hC5, 2'd1, 8'hA3, acc);
      in_valid = 1'b0; in_data = 8'hFF; in_mode = 2'd0;
      drain8();

      // Back-pressure in DONE: output holds, new offers are ignored.
      out_ready = 1'b0;
      send8(8'hC5, 2'd1, 8'hA3, acc);
      in_valid = 1'b0;
      t = 0;
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      if (!out_valid) fail_now("done_timeout");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("done_in_ready", {31'h0, in_ready}, 32'h0);
         check("done_out_valid", {31'h0, out_valid}, 32'h1);
         in_valid = 1'b1; in_data = 8'h55; in_mode = 2'd0;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("post_hs_in_ready", {31'h0, in_ready}, 32'h1);
      check("post_hs_busy", {31'h0, busy}, 32'h0);
      check("post_hs_out_valid", {31'h0, out_valid}, 32'h0);
      check("idle_out_data_hold", {24'h0, out_data}, 32'hA3);

      // Reset during RUN aborts the word, then a fresh word is accepted.
      send8(8'hC5, 2'd1, 8'hA3, acc);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_out_valid", {31'h0, out_valid}, 32'h0);
      check("abort_out_data", {24'h0, out_data}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_in_ready", {31'h0, in_ready}, 32'h1);
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      send8(8'h01, 2'd1, 8'h80, acc);
      in_valid = 1'b0;
      drain8();

      // Continuous in_valid: one word every NG+2 cycles.
      prev_acc = 0;
      for (int i = 0; i < 4; i++) begin
         send8(bd[i], bm[i], be[i], acc);
         if (i > 0) check("b2b_spacing", acc - prev_acc, NG8 + 2);
         prev_acc = acc;
      end
      in_valid = 1'b0;
      drain8();

      // Wider words: NG=4 and single-group NG=1 instances.
      send16(16'h1234, 2'd2, 16'h4321, 16'h1234);
      send16(16'h1234, 2'd1, 16'h2C48, 16'h2C48);
      send16(16'h0001, 2'd1, 16'h8000, 16'h8000);

      repeat (3) @(negedge clk);
      if (q8.size() != 0) fail_now("leftover_expected8");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/bit_reverse_unit.md
BIT_REVERSE_UNIT -- requirements
Module: bit_reverse_unit

Interface
REQ-001 SHALL have parameter N_BITS, default 8, data word width.
REQ-002 SHALL have parameter GROUP_W, default 4, group width; N_BITS SHALL be an integer multiple of GROUP_W, GROUP_W >= 1; NG = N_BITS/GROUP_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input word offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_data  input  N_BITS  word to transform.
REQ-008 SHALL have port in_mode  input  2  transform select: 00 pass, 01 full bit reverse, 10 group-order swap, 11 reverse bits within each group.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_data  output  N_BITS  transformed word.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-014 IDLE: on edge with in_valid=1, SHALL latch in_data and in_mode, clear group index g to 0, clear work register, go to RUN.
REQ-015 RUN: each cycle SHALL write exactly one output group g (bits g*GROUP_W .. g*GROUP_W+GROUP_W-1) of the work register, then increment g.
REQ-016 Group source per latched mode: 00 -> source group g unchanged; 01 -> source group NG-1-g, bit-reversed; 10 -> source group NG-1-g unchanged; 11 -> source group g, bit-reversed.
REQ-017 Mode 01 SHALL equal full N_BITS bit reversal: out[i] = in[N_BITS-1-i].
REQ-018 On the RUN cycle writing g = NG-1, SHALL load out_data with the complete result and go to DONE.
REQ-019 Latency: word accepted at edge k SHALL give out_valid=1 after edge k+NG; NG=1 (GROUP_W=N_BITS) gives one cycle.
REQ-020 DONE: out_valid and out_data SHALL hold stable until an edge with out_ready=1, then go to IDLE.
REQ-021 out_data SHALL change only on DONE entry or reset; it holds its last value in IDLE and RUN.
REQ-022 in_valid, in_data and in_mode SHALL be ignored outside IDLE; latched mode/data SHALL not be affected by input changes during RUN or DONE.
REQ-023 No overlap: a new word SHALL be accepted no earlier than the edge after the DONE->IDLE handshake edge.
REQ-024 g SHALL be sized ceil(log2(NG)) bits, minimum 1, and never exceed NG-1.
REQ-025 With GROUP_W=1, modes 01 and 10 SHALL both produce full bit reversal, and mode 11 SHALL equal pass.

Reset
REQ-026 While rst=1, asynchronously: state=IDLE, g=0, work register=0, out_data=0, out_valid=0, busy=0; in_ready=1.
REQ-027 Reset asserted in RUN or DONE SHALL abort the word with no result; the first edge after release with in_valid=1 SHALL accept a new word.

Verification (N_BITS=8, GROUP_W=4 unless stated)
REQ-028 in_data=0xC5 in each mode, out_ready=1 -> out_data 00:0xC5, 01:0xA3, 10:0x5C, 11:0x3A, each with out_valid high 2 cycles after acceptance.
REQ-029 mode 01, 0xC5, out_ready=0 for 3 cycles in DONE -> out_valid=1 and out_data=0xA3 stable throughout, in_ready=0, in_valid pulses ignored; IDLE after out_ready=1.
REQ-030 in_data/in_mode changed to 0xFF/00 during RUN -> result still from latched word (0xC5 mode 01 -> 0xA3).
REQ-031 rst pulsed during RUN -> immediately out_valid=0, out_data=0, busy=0; next accepted 0x01 mode 01 -> 0x80.
REQ-032 N_BITS=16, GROUP_W=4, 0x1234 mode 10 -> 0x4321 after 4 cycles; mode 01 -> 0x2C48; GROUP_W=16, 0x0001 mode 01 -> 0x8000 after 1 cycle.
REQ-033 Back-to-back in_valid=1 continuously with out_ready=1 -> one word per NG+2 cycles, none dropped or duplicated.
